bcd_calendar_counter: RTL and testbench

//  Parametrised BCD real-time calendar: sec/min/hour/day/month/year with month-length rules,
//  a loadable time/date, 12/24-hour presentation and a tick prescaler. Advances on a

---
 rtl/bcd_calendar_counter.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_bcd_calendar_counter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_calendar_counter.sv
// bcd_calendar_counter
//   BCD real-time calendar: seconds, minutes, hours (24 h), day, month and a
//   YEAR_DIGITS-digit year. A single-cycle tick_en strobe, divided by TICK_DIV,
//   advances the time by one second with a full digit-wise BCD ripple in one cycle.
//   A load strobe writes the whole time/date after validation; rejected loads
//   pulse load_err. hour_disp presents the hour in 12- or 24-hour form.
//   Optional feature macro: LEAP_YEAR_EN (February gets 29 days in leap years;
//   without it February always has 28 days).
module bcd_calendar_counter #(
   parameter int          YEAR_DIGITS = 4,
   parameter logic [15:0] RESET_YEAR  = 16'h2013,
   parameter int          TICK_DIV    = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     tick_en,
   input  logic                     hold,
   input  logic                     mode12,
   input  logic                     load,
   input  logic [7:0]               ld_sec,
   input  logic [7:0]               ld_min,
   input  logic [7:0]               ld_hour,
   input  logic [7:0]               ld_day,
   input  logic [7:0]               ld_month,
   input  logic [4*YEAR_DIGITS-1:0] ld_year,
   output logic [7:0]               sec,
   output logic [7:0]               min,
   output logic [7:0]               hour,
   output logic [7:0]               hour_disp,
   output logic                     pm,
   output logic [7:0]               day,
   output logic [7:0]               month,
   output logic [4*YEAR_DIGITS-1:0] year,
   output logic                     day_strobe,
   output logic                     load_err
);

   localparam int YW     = 4 * YEAR_DIGITS;
   localparam int PCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);

   // ------------------------------------------------------------------
   // BCD helper functions
   // ------------------------------------------------------------------

   // Both nibbles of a two-digit value are decimal digits.
   function automatic logic bcd2_ok(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   // Every nibble of a year value is a decimal digit.
   function automatic logic bcdn_ok(input logic [YW-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < YEAR_DIGITS; i++) begin
         ok = ok & (v[4*i +: 4] <= 4'd9);
      end
      return ok;
   endfunction

   // Two-digit BCD increment (callers handle the wrap value themselves).
   function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] >= 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   // Multi-digit BCD increment; all-9s naturally ripples to all-0s.
   function automatic logic [YW-1:0] bcdn_inc(input logic [YW-1:0] v);
      logic [YW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < YEAR_DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] >= 4'd9) begin
               r[4*i +: 4] = 4'd0;
               c           = 1'b1;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c           = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Days in a BCD month; unknown months return 0 so any day fails against it.
   function automatic logic [7:0] month_len(input logic [7:0] m, input logic leap);
      logic [7:0] len;
      case (m)
         8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: len = 8'h31;
         8'h04, 8'h06, 8'h09, 8'h11:                      len = 8'h30;
         8'h02:   len = leap ? 8'h29 : 8'h28;
         default: len = 8'h00;
      endcase
      return len;
   endfunction

`ifdef LEAP_YEAR_EN
   // Divisibility by 4 of a two-digit BCD number t*10+o, using 10 == 2 (mod 4):
   // even tens need ones 0/4/8, odd tens need ones 2/6.
   function automatic logic bcd_div4(input logic [3:0] t, input logic [3:0] o);
      logic r;
      if (t[0]) begin
         r = (o == 4'd2) || (o == 4'd6);
      end else begin
         r = (o == 4'd0) || (o == 4'd4) || (o == 4'd8);
      end
      return r;
   endfunction

   // Gregorian leap rule on BCD digits; the century exception needs four digits.
   function automatic logic is_leap(input logic [YW-1:0] y);
      logic [15:0] p;
      logic        r;
      p = 16'(y);
      if ((YEAR_DIGITS == 4) && (p[7:0] == 8'h00)) begin
         r = bcd_div4(p[15:12], p[11:8]);
      end else begin
         r = bcd_div4(p[7:4], p[3:0]);
      end
      return r;
   endfunction
`endif

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [7:0]        sec_r, min_r, hour_r, day_r, month_r;
   logic [YW-1:0]     year_r;
   logic [PCNT_W-1:0] pcnt_r;
   logic              pm_r, day_strobe_r, load_err_r;

   logic [7:0]        sec_s, min_s, hour_s, day_s, month_s;
   logic [YW-1:0]     year_s;
   logic [PCNT_W-1:0] pcnt_s;
   logic              day_strobe_s, load_err_s;

   logic              cur_leap_s, ld_leap_s;
   logic [7:0]        cur_len_s, ld_len_s;
   logic              ld_ok_s;
   logic [7:0]        h12_s;

`ifdef LEAP_YEAR_EN
   assign cur_leap_s = is_leap(year_r);
   assign ld_leap_s  = is_leap(ld_year);
`else
   assign cur_leap_s = 1'b0;
   assign ld_leap_s  = 1'b0;
`endif

   assign cur_len_s = month_len(month_r, cur_leap_s);
   assign ld_len_s  = month_len(ld_month, ld_leap_s);

   // A load is accepted only when every field is well-formed BCD and in range.
   assign ld_ok_s = bcd2_ok(ld_sec) && bcd2_ok(ld_min) && bcd2_ok(ld_hour) &&
                    bcd2_ok(ld_day) && bcd2_ok(ld_month) && bcdn_ok(ld_year) &&
                    (ld_sec  <= 8'h59) && (ld_min <= 8'h59) && (ld_hour <= 8'h23) &&
                    (ld_month != 8'h00) && (ld_month <= 8'h12) &&
                    (ld_day  != 8'h00) && (ld_day <= ld_len_s);

   // Next-state: load has priority and drops a coincident tick; otherwise a
   // prescaled tick ripples a one-second advance through every field.
   always_comb begin
      sec_s        = sec_r;
      min_s        = min_r;
      hour_s       = hour_r;
      day_s        = day_r;
      month_s      = month_r;
      year_s       = year_r;
      pcnt_s       = pcnt_r;
      day_strobe_s = 1'b0;
      load_err_s   = 1'b0;
      if (load) begin
         if (ld_ok_s) begin
            sec_s   = ld_sec;
            min_s   = ld_min;
            hour_s  = ld_hour;
            day_s   = ld_day;
            month_s = ld_month;
            year_s  = ld_year;
            pcnt_s  = {PCNT_W{1'b0}};
         end else begin
            load_err_s = 1'b1;
         end
      end else if (tick_en && !hold) begin
         if (pcnt_r == PCNT_LAST) begin
            pcnt_s = {PCNT_W{1'b0}};
            if (sec_r >= 8'h59) begin
               sec_s = 8'h00;
               if (min_r >= 8'h59) begin
                  min_s = 8'h00;
                  if (hour_r >= 8'h23) begin
                     hour_s       = 8'h00;
                     day_strobe_s = 1'b1;
                     if (day_r >= cur_len_s) begin
                        day_s = 8'h01;
                        if (month_r >= 8'h12) begin
                           month_s = 8'h01;
                           year_s  = bcdn_inc(year_r);
                        end else begin
                           month_s = bcd2_inc(month_r);
                        end
                     end else begin
                        day_s = bcd2_inc(day_r);
                     end
                  end else begin
                     hour_s = bcd2_inc(hour_r);
                  end
               end else begin
                  min_s = bcd2_inc(min_r);
               end
            end else begin
               sec_s = bcd2_inc(sec_r);
            end
         end else begin
            pcnt_s = pcnt_r + PCNT_W'(1);
         end
      end else begin
         pcnt_s = pcnt_r;
      end
   end

   // State register: asynchronous return to 00:00:00 01/01/RESET_YEAR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec_r        <= 8'h00;
         min_r        <= 8'h00;
         hour_r       <= 8'h00;
         day_r        <= 8'h01;
         month_r      <= 8'h01;
         year_r       <= RESET_YEAR[YW-1:0];
         pcnt_r       <= {PCNT_W{1'b0}};
         pm_r         <= 1'b0;
         day_strobe_r <= 1'b0;
         load_err_r   <= 1'b0;
      end else begin
         sec_r        <= sec_s;
         min_r        <= min_s;
         hour_r       <= hour_s;
         day_r        <= day_s;
         month_r      <= month_s;
         year_r       <= year_s;
         pcnt_r       <= pcnt_s;
         pm_r         <= (hour_s >= 8'h12);
         day_strobe_r <= day_strobe_s;
         load_err_r   <= load_err_s;
      end
   end

   // 12-hour presentation: 00 -> 12, 13..23 -> 01..11, others unchanged.
   always_comb begin
      case (hour_r)
         8'h00:   h12_s = 8'h12;
         8'h13:   h12_s = 8'h01;
         8'h14:   h12_s = 8'h02;
         8'h15:   h12_s = 8'h03;
         8'h16:   h12_s = 8'h04;
         8'h17:   h12_s = 8'h05;
         8'h18:   h12_s = 8'h06;
         8'h19:   h12_s = 8'h07;
         8'h20:   h12_s = 8'h08;
         8'h21:   h12_s = 8'h09;
         8'h22:   h12_s = 8'h10;
         8'h23:   h12_s = 8'h11;
         default: h12_s = hour_r;
      endcase
      if (mode12) begin
         hour_disp = h12_s;
      end else begin
         hour_disp = hour_r;
      end
   end

   assign sec        = sec_r;
   assign min        = min_r;
   assign hour       = hour_r;
   assign pm         = pm_r;
   assign day        = day_r;
   assign month      = month_r;
   assign year       = year_r;
   assign day_strobe = day_strobe_r;
   assign load_err   = load_err_r;

endmodule

// File: tb/tb_bcd_calendar_counter.sv
// Self-checking bench for bcd_calendar_counter (TICK_DIV = 4, four-digit year).
// Table-driven vectors plus hand-written reset sequences; expected results go
// through a scoreboard queue. Expectations follow LEAP_YEAR_EN when defined.
module tb_bcd_calendar_counter;

`ifdef LEAP_YEAR_EN
   localparam bit LEAP = 1'b1;
`else
   localparam bit LEAP = 1'b0;
`endif

   logic        clk, rst_n, tick_en, hold, mode12, load;
   logic [7:0]  ld_sec, ld_min, ld_hour, ld_day, ld_month;
   logic [15:0] ld_year;
   logic [7:0]  sec, min, hour, hour_disp, day, month;
   logic        pm, day_strobe, load_err;
   logic [15:0] year;

   bcd_calendar_counter #(
      .YEAR_DIGITS(4),
      .RESET_YEAR (16'h2013),
      .TICK_DIV   (4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .hold(hold), .mode12(mode12),
      .load(load), .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour),
      .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year),
      .sec(sec), .min(min), .hour(hour), .hour_disp(hour_disp), .pm(pm),
      .day(day), .month(month), .year(year),
      .day_strobe(day_strobe), .load_err(load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [23:0] hms;
      logic [7:0]  hd;
      logic        pm;
      logic [31:0] dmy;
      logic        ds;
      logic        err;
   } exp_t;

   typedef struct {
      bit          ld;
      int          ticks;
      bit          hold;
      bit          m12;
      logic [23:0] ld_hms;
      logic [31:0] ld_dmy;
      exp_t        e;
   } vec_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic add(input string nm, input bit ld, input int ticks, input bit hd_in,
                      input bit m12, input logic [23:0] lhms, input logic [31:0] ldmy,
                      input logic [23:0] ehms, input logic [7:0] ehd, input logic epm,
                      input logic [31:0] edmy, input logic eds, input logic eerr);
      vec_t v;
      v.ld = ld; v.ticks = ticks; v.hold = hd_in; v.m12 = m12;
      v.ld_hms = lhms; v.ld_dmy = ldmy;
      v.e.name = nm; v.e.hms = ehms; v.e.hd = ehd; v.e.pm = epm;
      v.e.dmy = edmy; v.e.ds = eds; v.e.err = eerr;
      vecs.push_back(v);
   endtask

   task automatic push_exp(input string nm, input logic [23:0] ehms, input logic [7:0] ehd,
                           input logic epm, input logic [31:0] edmy);
      exp_t e;
      e.name = nm; e.hms = ehms; e.hd = ehd; e.pm = epm; e.dmy = edmy;
      e.ds = 1'b0; e.err = 1'b0;
      sb.push_back(e);
   endtask

   task automatic check_pop();
      exp_t        e;
      logic [23:0] a_hms;
      logic [31:0] a_dmy;
      n_vec++;
      if (sb.size() == 0) begin
         n_miss++;
         $display("FAIL scoreboard: no expected entry queued");
      end else begin
         e     = sb.pop_front();
         a_hms = {hour, min, sec};
         a_dmy = {day, month, year};
         if (a_hms !== e.hms || hour_disp !== e.hd || pm !== e.pm || a_dmy !== e.dmy ||
             day_strobe !== e.ds || load_err !== e.err) begin
            n_miss++;
            $display("FAIL %s: got hms=%h hd=%h pm=%b dmy=%h ds=%b err=%b, want hms=%h hd=%h pm=%b dmy=%h ds=%b err=%b",
                     e.name, a_hms, hour_disp, pm, a_dmy, day_strobe, load_err,
                     e.hms, e.hd, e.pm, e.dmy, e.ds, e.err);
         end
      end
   endtask

   // One vector: a load cycle (optionally with a coincident tick) or a run of ticks.
   task automatic apply(input vec_t v);
      int n;
      n      = v.ld ? 1 : v.ticks;
      hold   = v.hold;
      mode12 = v.m12;
      for (int c = 0; c < n; c++) begin
         load     = v.ld;
         tick_en  = v.ld ? (v.ticks > 0) : 1'b1;
         ld_hour  = v.ld_hms[23:16];
         ld_min   = v.ld_hms[15:8];
         ld_sec   = v.ld_hms[7:0];
         ld_day   = v.ld_dmy[31:24];
         ld_month = v.ld_dmy[23:16];
         ld_year  = v.ld_dmy[15:0];
         if (c == n - 1) sb.push_back(v.e);
         @(posedge clk);
         #1;
         load    = 1'b0;
         tick_en = 1'b0;
         if (c == n - 1) check_pop();
      end
      hold = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; tick_en = 1'b0; hold = 1'b0; mode12 = 1'b0; load = 1'b0;
      ld_sec = 8'h00; ld_min = 8'h00; ld_hour = 8'h00; ld_day = 8'h00;
      ld_month = 8'h00; ld_year = 16'h0000;

      //   name        ld tk hd m12 ld_hms      ld_dmy        exp_hms     hd     pm    exp_dmy       ds    err
      add("ld_nye",    1, 0, 0, 0, 24'h235959, 32'h31122013, 24'h235959, 8'h23, 1'b1, 32'h31122013, 1'b0, 1'b0);
      add("roll_nye",  0, 4, 0, 0, 24'h000000, 32'h00000000, 24'h000000, 8'h00, 1'b0, 32'h01012014, 1'b1, 1'b0);
      add("sec1",      0, 4, 0, 0, 24'h000000, 32'h00000000, 24'h000001, 8'h00, 1'b0, 32'h01012014, 1'b0, 1'b0);
      add("presc3",    0, 3, 0, 0, 24'h000000, 32'h00000000, 24'h000001, 8'h00, 1'b0, 32'h01012014, 1'b0, 1'b0);
      add("hold3",     0, 3, 1, 0, 24'h000000, 32'h00000000, 24'h000001, 8'h00, 1'b0, 32'h01012014, 1'b0, 1'b0);
      add("resume1",   0, 1, 0, 0, 24'h000000, 32'h00000000, 24'h000002, 8'h00, 1'b0, 32'h01012014, 1'b0, 1'b0);
      add("pre2",      0, 2, 0, 0, 24'h000000, 32'h00000000, 24'h000002, 8'h00, 1'b0, 32'h01012014, 1'b0, 1'b0);
      add("ld_1159",   1, 0, 0, 0, 24'h115959, 32'h15062014, 24'h115959, 8'h11, 1'b0, 32'h15062014, 1'b0, 1'b0);
      add("pcnt_clr",  0, 3, 0, 0, 24'h000000, 32'h00000000, 24'h115959, 8'h11, 1'b0, 32'h15062014, 1'b0, 1'b0);
      add("noon",      0, 1, 0, 0, 24'h000000, 32'h00000000, 24'h120000, 8'h12, 1'b1, 32'h15062014, 1'b0, 1'b0);
      add("pre3",      0, 3, 0, 0, 24'h000000, 32'h00000000, 24'h120000, 8'h12, 1'b1, 32'h15062014, 1'b0, 1'b0);
      add("ld_tick",   1, 1, 0, 0, 24'h105959, 32'h15062014, 24'h105959, 8'h10, 1'b0, 32'h15062014, 1'b0, 1'b0);
      add("post_lt3",  0, 3, 0, 0, 24'h000000, 32'h00000000, 24'h105959, 8'h10, 1'b0, 32'h15062014, 1'b0, 1'b0);
      add("min_carry", 0, 1, 0, 0, 24'h000000, 32'h00000000, 24'h110000, 8'h11, 1'b0, 32'h15062014, 1'b0, 1'b0);
      add("hold_ld",   1, 0, 1, 0, 24'h010203, 32'h04072014, 24'h010203, 8'h01, 1'b0, 32'h04072014, 1'b0, 1'b0);
      add("h00_12",    1, 0, 0, 1, 24'h000000, 32'h01012014, 24'h000000, 8'h12, 1'b0, 32'h01012014, 1'b0, 1'b0);
      add("h12_12",    1, 0, 0, 1, 24'h120000, 32'h01012014, 24'h120000, 8'h12, 1'b1, 32'h01012014, 1'b0, 1'b0);
      add("h13_12",    1, 0, 0, 1, 24'h130000, 32'h01012014, 24'h130000, 8'h01, 1'b1, 32'h01012014, 1'b0, 1'b0);
      add("h23_12",    1, 0, 0, 1, 24'h234500, 32'h01012014, 24'h234500, 8'h11, 1'b1, 32'h01012014, 1'b0, 1'b0);
      add("h09_12",    1, 0, 0, 1, 24'h093000, 32'h01012014, 24'h093000, 8'h09, 1'b0, 32'h01012014, 1'b0, 1'b0);
      add("bad_h24",   1, 0, 0, 0, 24'h240000, 32'h01012014, 24'h093000, 8'h09, 1'b0, 32'h01012014, 1'b0, 1'b1);
      add("bad_mo13",  1, 0, 0, 0, 24'h000000, 32'h01132014, 24'h093000, 8'h09, 1'b0, 32'h01012014, 1'b0, 1'b1);
      add("bad_nibA",  1, 0, 0, 0, 24'h00005A, 32'h01012014, 24'h093000, 8'h09, 1'b0, 32'h01012014, 1'b0, 1'b1);
      add("bad_min60", 1, 0, 0, 0, 24'h006000, 32'h01012014, 24'h093000, 8'h09, 1'b0, 32'h01012014, 1'b0, 1'b1);
      add("bad_mo00",  1, 0, 0, 0, 24'h000000, 32'h01002014, 24'h093000, 8'h09, 1'b0, 32'h01012014, 1'b0, 1'b1);
      add("bad_d00",   1, 0, 0, 0, 24'h000000, 32'h00012014, 24'h093000, 8'h09, 1'b0, 32'h01012014, 1'b0, 1'b1);
      add("bad_d32",   1, 0, 0, 0, 24'h000000, 32'h32012014, 24'h093000, 8'h09, 1'b0, 32'h01012014, 1'b0, 1'b1);
      add("bad_apr31", 1, 0, 0, 0, 24'h000000, 32'h31042014, 24'h093000, 8'h09, 1'b0, 32'h01012014, 1'b0, 1'b1);
      add("bad_yrA",   1, 0, 0, 0, 24'h000000, 32'h010120A0, 24'h093000, 8'h09, 1'b0, 32'h01012014, 1'b0, 1'b1);
      add("ld_apr30",  1, 0, 0, 0, 24'h235959, 32'h30042014, 24'h235959, 8'h23, 1'b1, 32'h30042014, 1'b0, 1'b0);
      add("roll_apr",  0, 4, 0, 0, 24'h000000, 32'h00000000, 24'h000000, 8'h00, 1'b0, 32'h01052014, 1'b1, 1'b0);
      add("ld_jan30",  1, 0, 0, 0, 24'h235959, 32'h30012014, 24'h235959, 8'h23, 1'b1, 32'h30012014, 1'b0, 1'b0);
      add("roll_jan",  0, 4, 0, 0, 24'h000000, 32'h00000000, 24'h000000, 8'h00, 1'b0, 32'h31012014, 1'b1, 1'b0);
      add("ld_9999",   1, 0, 0, 0, 24'h235959, 32'h31129999, 24'h235959, 8'h23, 1'b1, 32'h31129999, 1'b0, 1'b0);
      add("roll_9999", 0, 4, 0, 0, 24'h000000, 32'h00000000, 24'h000000, 8'h00, 1'b0, 32'h01010000, 1'b1, 1'b0);
      add("ld_f2015",  1, 0, 0, 0, 24'h235959, 32'h28022015, 24'h235959, 8'h23, 1'b1, 32'h28022015, 1'b0, 1'b0);
      add("roll_f15",  0, 4, 0, 0, 24'h000000, 32'h00000000, 24'h000000, 8'h00, 1'b0, 32'h01032015, 1'b1, 1'b0);
      add("ld_f2010",  1, 0, 0, 0, 24'h235959, 32'h28022010, 24'h235959, 8'h23, 1'b1, 32'h28022010, 1'b0, 1'b0);
      add("roll_f10",  0, 4, 0, 0, 24'h000000, 32'h00000000, 24'h000000, 8'h00, 1'b0, 32'h01032010, 1'b1, 1'b0);
      add("ld_f2012",  1, 0, 0, 0, 24'h235959, 32'h28022012, 24'h235959, 8'h23, 1'b1, 32'h28022012, 1'b0, 1'b0);
      add("roll_f12",  0, 4, 0, 0, 24'h000000, 32'h00000000, 24'h000000, 8'h00, 1'b0,
          LEAP ? 32'h29022012 : 32'h01032012, 1'b1, 1'b0);
      add("ld_f2016",  1, 0, 0, 0, 24'h235959, 32'h28022016, 24'h235959, 8'h23, 1'b1, 32'h28022016, 1'b0, 1'b0);
      add("roll_f16",  0, 4, 0, 0, 24'h000000, 32'h00000000, 24'h000000, 8'h00, 1'b0,
          LEAP ? 32'h29022016 : 32'h01032016, 1'b1, 1'b0);
      add("ld_2902_16", 1, 0, 0, 0, 24'h120000, 32'h29022016,
          LEAP ? 24'h120000 : 24'h000000, LEAP ? 8'h12 : 8'h00, LEAP,
          LEAP ? 32'h29022016 : 32'h01032016, 1'b0, !LEAP);
      add("ld_2902_15", 1, 0, 0, 0, 24'h120000, 32'h29022015,
          LEAP ? 24'h120000 : 24'h000000, LEAP ? 8'h12 : 8'h00, LEAP,
          LEAP ? 32'h29022016 : 32'h01032016, 1'b0, 1'b1);
      add("ld_f2100",  1, 0, 0, 0, 24'h235959, 32'h28022100, 24'h235959, 8'h23, 1'b1, 32'h28022100, 1'b0, 1'b0);
      add("roll_2100", 0, 4, 0, 0, 24'h000000, 32'h00000000, 24'h000000, 8'h00, 1'b0, 32'h01032100, 1'b1, 1'b0);
      add("ld_f2000",  1, 0, 0, 0, 24'h235959, 32'h28022000, 24'h235959, 8'h23, 1'b1, 32'h28022000, 1'b0, 1'b0);
      add("roll_2000", 0, 4, 0, 0, 24'h000000, 32'h00000000, 24'h000000, 8'h00, 1'b0,
          LEAP ? 32'h29022000 : 32'h01032000, 1'b1, 1'b0);

      // Reset state, including the mode12 view of hour 00.
      repeat (2) @(posedge clk);
      #1;
      push_exp("reset_state", 24'h000000, 8'h00, 1'b0, 32'h01012013);
      check_pop();
      mode12 = 1'b1;
      push_exp("reset_m12", 24'h000000, 8'h12, 1'b0, 32'h01012013);
      #1;
      check_pop();
      mode12 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) apply(vecs[i]);

      // Reset asserted mid-count: values return at once and stay through the next edge.
      tick_en = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      tick_en = 1'b0;
      #2;
      rst_n = 1'b0;
      push_exp("midreset_async", 24'h000000, 8'h00, 1'b0, 32'h01012013);
      #1;
      check_pop();
      push_exp("midreset_edge", 24'h000000, 8'h00, 1'b0, 32'h01012013);
      @(posedge clk);
      #1;
      check_pop();
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
